// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a line-wide block RAM. It has independent read and
// write FSMs and one outstanding transaction per direction.
module axi_mem_responder #(
   parameter int unsigned LINE_BITS = 10
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [28:0]  araddr,
   input  logic [1:0]   arburst,
   input  logic [3:0]   arid,
   input  logic [7:0]   arlen,
   input  logic [2:0]   arsize,
   input  logic [3:0]   arcache,
   input  logic         arlock,
   input  logic [2:0]   arprot,
   input  logic [3:0]   arqos,
   input  logic         arvalid,
   output logic         arready,
   output logic [511:0] rdata,
   output logic [3:0]   rid,
   output logic [1:0]   rresp,
   output logic         rlast,
   output logic         rvalid,
   input  logic         rready,
   input  logic [28:0]  awaddr,
   input  logic [1:0]   awburst,
   input  logic [3:0]   awid,
   input  logic [7:0]   awlen,
   input  logic [2:0]   awsize,
   input  logic [3:0]   awcache,
   input  logic         awlock,
   input  logic [2:0]   awprot,
   input  logic [3:0]   awqos,
   input  logic         awvalid,
   output logic         awready,
   input  logic [511:0] wdata,
   input  logic [63:0]  wstrb,
   input  logic         wlast,
   input  logic         wvalid,
   output logic         wready,
   output logic [3:0]   bid,
   output logic [1:0]   bresp,
   output logic         bvalid,
   input  logic         bready
);

   typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   logic [511:0] mem [2**LINE_BITS];
   logic [511:0] ram_rd_q;

   r_state_e             r_state_q;
   logic [LINE_BITS-1:0] rline_q;
   logic [7:0]           rlen_q, rcnt_q;
   logic [3:0]           rid_q;
   logic                 rfixed_q, arready_q, rvalid_q, rlast_q;
   logic [511:0]         rdata_q;

   w_state_e             w_state_q;
   logic [LINE_BITS-1:0] wline_q;
   logic [7:0]           wlen_q, wcnt_q;
   logic [3:0]           wid_q, bid_q;
   logic                 wfixed_q, awready_q, wready_q, bvalid_q, werr_q;
   logic [1:0]           bresp_q;

   logic w_fire, w_final;
   assign w_fire  = wvalid && wready_q;
   assign w_final = (wcnt_q == wlen_q);

   logic unused_inputs;
   assign unused_inputs = ^{araddr[5:0], araddr[28:LINE_BITS+6], arsize, arcache, arlock,
                            arprot, arqos, awaddr[5:0], awaddr[28:LINE_BITS+6], awsize,
                            awcache, awlock, awprot, awqos};

   // Nonblocking read and write at the same edge give read-before-write ordering.
   always_ff @(posedge clk) begin
      if (r_state_q == R_READ) ram_rd_q <= mem[rline_q];
      if (w_fire) begin
         for (int unsigned i = 0; i < 64; i++) begin
            if (wstrb[i]) mem[wline_q][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rid_q     <= '0;
         rline_q   <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rfixed_q  <= 1'b0;
      end else begin
         unique case (r_state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (arvalid && arready_q) begin
                  arready_q <= 1'b0;
                  rline_q   <= araddr[LINE_BITS+5:6];
                  rlen_q    <= arlen;
                  rid_q     <= arid;
                  rfixed_q  <= (arburst == 2'b00);
                  rcnt_q    <= '0;
                  r_state_q <= R_READ;
               end
            end
            R_READ: r_state_q <= R_DATA;
            R_DATA: begin
               // First cycle in R_DATA registers the RAM output; then hold until accepted.
               if (!rvalid_q) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= ram_rd_q;
                  rlast_q  <= (rcnt_q == rlen_q);
               end else if (rready) begin
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  if (rlast_q) begin
                     arready_q <= 1'b1;
                     r_state_q <= R_IDLE;
                  end else begin
                     rcnt_q    <= rcnt_q + 8'd1;
                     rline_q   <= rline_q + {{(LINE_BITS-1){1'b0}}, ~rfixed_q};
                     r_state_q <= R_READ;
                  end
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         werr_q    <= 1'b0;
         wline_q   <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         wid_q     <= '0;
         wfixed_q  <= 1'b0;
      end else begin
         unique case (w_state_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (awvalid && awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wline_q   <= awaddr[LINE_BITS+5:6];
                  wlen_q    <= awlen;
                  wid_q     <= awid;
                  wfixed_q  <= (awburst == 2'b00);
                  wcnt_q    <= '0;
                  werr_q    <= 1'b0;
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  if (w_final) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bid_q     <= wid_q;
                     bresp_q   <= (werr_q || !wlast) ? 2'b10 : 2'b00;
                     werr_q    <= werr_q || !wlast;
                     w_state_q <= W_RESP;
                  end else begin
                     if (wlast) werr_q <= 1'b1;
                     wcnt_q  <= wcnt_q + 8'd1;
                     wline_q <= wline_q + {{(LINE_BITS-1){1'b0}}, ~wfixed_q};
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  werr_q    <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rid     = rid_q;
   assign rresp   = '0;
   assign rlast   = rlast_q;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bid     = bid_q;
   assign bresp   = bresp_q;

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

- AXI4 slave (responder) backed by on-chip block RAM.
- Serves the 512-bit / 29-bit-address AXI4 master port driven by the core's `exec` stage. Used as the simulation and FPGA-bring-up stand-in for DRAM.
- Read and write channels run independently, each under its own FSM, and share one line-wide memory array with per-byte write strobes.

## Interface

Parameters:
- `LINE_BITS`, default 10: log2 of the memory depth in 64-byte lines.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `araddr`  in  29  read byte address. Bits [5:0] are ignored; line index is `araddr[LINE_BITS+5:6]`.
- `arburst`  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP (WRAP is handled as INCR).
- `arid`  in  4  read ID, echoed on `rid`.
- `arlen`  in  8  beats minus one.
- `arsize`, `arcache`, `arlock`, `arprot`, `arqos`  in  3/4/1/3/4  accepted and ignored; every beat is a full line.
- `arvalid` in 1 / `arready` out 1  AR handshake.
- `rdata` out 512, `rid` out 4, `rresp` out 2, `rlast` out 1  read beat.
- `rvalid` out 1 / `rready` in 1  R handshake.
- `awaddr`, `awburst`, `awid`, `awlen`  in  29/2/4/8  same meaning as the AR fields.
- `awsize`, `awcache`, `awlock`, `awprot`, `awqos`  in  3/4/1/3/4  ignored.
- `awvalid` in 1 / `awready` out 1  AW handshake.
- `wdata` in 512, `wstrb` in 64, `wlast` in 1  write beat. `wstrb[i]` enables byte `wdata[8i+7:8i]`.
- `wvalid` in 1 / `wready` out 1  W handshake.
- `bid` out 4, `bresp` out 2  write response.
- `bvalid` out 1 / `bready` in 1  B handshake.

## Operation

Read FSM:
- **R_IDLE**: `arready`=1. On `arvalid&&arready`, capture line index, len, id and burst, then go to R_READ.
- **R_READ**: `arready`=0. Issue a synchronous RAM read of the current line, then go to R_DATA.
- **R_DATA**: `rvalid`=1 with `rdata` registered from the RAM; `rid`=captured id; `rresp`=00; `rlast`=1 when beat count equals len.
  - On `rvalid&&rready` with `rlast`: go to R_IDLE.
  - On `rvalid&&rready` otherwise: advance line (+1 for INCR/WRAP, +0 for FIXED) and return to R_READ.

Write FSM:
- **W_IDLE**: `awready`=1. On handshake, capture line index, len, id and burst, then go to W_DATA.
- **W_DATA**: `wready`=1. Each `wvalid&&wready` writes the strobed bytes of the current line at that edge and advances the line as for reads.
  - The burst ends on the beat where the count equals len; `wlast` never ends a burst.
  - An error flag is set if `wlast`≠(count==len) on any beat.
  - After the final beat, go to W_RESP.
- **W_RESP**: `bvalid`=1, `bid`=captured id, `bresp`=10 (SLVERR) if the error flag is set, else 00. On `bready`, clear the flag and go to W_IDLE.

Rules and boundary conditions:
- Line index wraps modulo 2^LINE_BITS, both at the start address and during INCR advance.
- The beat counter is 8 bits: len 255 gives 256 beats, with no overflow before `rlast`.
- Once asserted, `rvalid`/`bvalid` and their payloads stay stable until the handshake completes.
- Simultaneous read and write of the same line in the same cycle is read-before-write: the read returns the old data.
- Read and write FSMs never stall each other.

## Timing

- Reset, asynchronous with `rstn`=0:
  - Every output goes to 0 immediately: `arready`, `awready`, `wready`, `rvalid`, `rlast`, `bvalid`, `rdata`, `rid`, `rresp`, `bid`, `bresp`.
  - Both FSMs return to IDLE; any in-flight burst is discarded with no response.
  - Memory contents are not reset.
  - In the first clock edge after `rstn` rises, `arready` and `awready` go to 1.
- Read latency: AR handshake at edge N gives `rvalid` high after edge N+2. Each later beat arrives 2 cycles after the previous R handshake.
- Write:
  - AW handshake at edge N gives `wready` high after edge N.
  - One beat per cycle while `wvalid` is held high.
  - `bvalid` rises after the edge that accepts the final beat.
- `awready` stays 0 from the AW handshake until the B handshake; `arready` stays 0 until the last R handshake. At most one outstanding transaction per direction.

## Test plan

- **Single write, single read**: AW 0x40, len 0, `wstrb` all ones, `wdata`={16{32'hA5A50000+i}}; then AR 0x40, len 0, id 3.
  - Required: `bresp` 00; `rdata` equals the written data; `rid` 3; `rlast` 1; `rvalid` 2 cycles after AR.
- **Partial strobe**: fill line 0 with all-ones, then write with `wstrb`=64'hF, `wdata[31:0]`=32'h12345678.
  - Required: the read returns low word 12345678 and all other bytes FF.
- **INCR read burst with back-pressure**: lines 0–3 pre-loaded, AR 0x0, len 3, `rready` toggled every other cycle.
  - Required: 4 beats in line order; `rlast` only on beat 4; `rdata` held while `rready`=0.
- **FIXED write with wlast error**: AW 0x80, FIXED, len 1, beat 0 carries `wlast`=1.
  - Required: both beats are accepted; the second beat's data is stored; `bresp` 10.
- **Concurrent traffic**: same-cycle AW/W and AR to line 5.
  - Required: the read returns the pre-write data; a second read returns the new data.
- **Reset mid-burst**: `rstn` pulled low at beat 2 of a len-7 read.
  - Required: `rvalid` goes to 0 asynchronously; after release `arready`=1 one edge later; a re-read returns the data written before reset.
